// File: rtl/relay_pkg.sv
// Shared types and constants for the relay link receiver.
package relay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned FRAME_BITS       = 8;
  localparam int unsigned DEFAULT_BIT_CLKS = 16;

  // 2-of-3 majority used for every bit decision.
  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/link_sync.sv
// Synchronizer for the raw link pin plus a one-clock delayed copy for edge detection.
module link_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic ck_1356meg,
  input  logic rst,
  input  logic link_pin,
  output logic s,
  output logic s_prev
);

  logic [SYNC_STAGES-1:0] sync_ff;

  // Chain and delayed copy reset high so a line already high at release never looks like a start.
  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) begin
      sync_ff <= '1;
      s_prev  <= 1'b1;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], link_pin};
      s_prev  <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign s = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/relay_link_rx.sv
// Relay link receiver: start bit, 8 data bits MSB first, stop bit, 3-sample mid-bit vote.
module relay_link_rx #(
  parameter int unsigned BIT_CLKS    = relay_pkg::DEFAULT_BIT_CLKS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       link_pin,
  output logic       link_bit,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);
  import relay_pkg::*;

  localparam int unsigned H  = BIT_CLKS / 2;
  localparam int unsigned CW = $clog2(BIT_CLKS);

  localparam logic [CW-1:0] CNT_SAMP_A = CW'(H - 1);
  localparam logic [CW-1:0] CNT_SAMP_B = CW'(H);
  localparam logic [CW-1:0] CNT_DEC    = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(BIT_CLKS - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(FRAME_BITS - 1);

  logic          s;
  logic          s_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          samp_a;
  logic          samp_b;
  logic          rise;
  logic          at_dec;
  logic          at_last;
  logic          voted;

  link_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .ck_1356meg(ck_1356meg),
    .rst       (rst),
    .link_pin  (link_pin),
    .s         (s),
    .s_prev    (s_prev)
  );

  // Edge detect, counter decodes and the vote on the two stored samples plus the live one.
  always_comb begin
    rise    = s & ~s_prev;
    at_dec  = (cnt == CNT_DEC);
    at_last = (cnt == CNT_LAST);
    voted   = vote3(samp_a, samp_b, s);
  end

  // Framing FSM with counters, sampler, shift register and registered outputs.
  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      link_bit  <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (cnt == CNT_SAMP_A) samp_a <= s;
      if (cnt == CNT_SAMP_B) samp_b <= s;
      cnt <= at_last ? '0 : cnt + CW'(1);

      unique case (state)
        IDLE: begin
          // Hold the counter at zero so START begins a fresh bit.
          cnt <= '0;
          if (rise) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (at_dec) begin
            link_bit <= voted;
            if (!voted) begin
              // Start glitch: abandon quietly.
              state    <= IDLE;
              busy     <= 1'b0;
              link_bit <= 1'b0;
            end
          end else if (at_last) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (at_dec) begin
            shreg    <= {shreg[6:0], voted};
            link_bit <= voted;
          end
          if (at_last) begin
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (at_dec) begin
            // Leave at the decision; the rest of the stop bit is not waited out.
            state    <= IDLE;
            busy     <= 1'b0;
            link_bit <= 1'b0;
            if (!voted) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relay_link_rx.sv
// Directed self-checking bench for relay_link_rx.
module tb_relay_link_rx;

  localparam int unsigned BIT_CLKS = 16;

  logic       ck_1356meg = 1'b0;
  logic       rst;
  logic       link_pin;
  logic       link_bit;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;

  always #5 ck_1356meg = ~ck_1356meg;

  relay_link_rx #(
    .BIT_CLKS   (BIT_CLKS),
    .SYNC_STAGES(2)
  ) dut (
    .ck_1356meg(ck_1356meg),
    .rst       (rst),
    .link_pin  (link_pin),
    .link_bit  (link_bit),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .err_count (err_count),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Pulse monitor.
  int         valid_cnt      = 0;
  int         err_pulse_cnt  = 0;
  int         both_cnt       = 0;
  int         last_valid_cyc = -1;
  int         prev_valid_cyc = -1;
  int         last_err_cyc   = -1;
  logic [7:0] last_byte      = '0;
  logic [7:0] prev_byte      = '0;
  logic [9:0] lb_bits;

  always @(posedge ck_1356meg) cyc <= cyc + 1;

  always @(negedge ck_1356meg) begin
    if (rx_valid) begin
      valid_cnt      <= valid_cnt + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
      prev_byte      <= last_byte;
      last_byte      <= rx_byte;
    end
    if (frame_err) begin
      err_pulse_cnt <= err_pulse_cnt + 1;
      last_err_cyc  <= cyc;
    end
    if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ck_1356meg);
  endtask

  // Sends start(1), 8 data bits MSB first, stop; called at a negedge. spike_at inverts the line
  // for one clock at that position inside every data bit (-1 = none). t0 = posedges so far.
  task automatic send_frame(input logic [7:0] data, input logic stop_val, input int spike_at,
                            output int t0);
    logic [9:0] bits;
    logic       spike;
    bits = {1'b1, data, stop_val};
    t0   = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < int'(BIT_CLKS); c++) begin
        spike    = (k >= 1) && (k <= 8) && (c == spike_at);
        link_pin = bits[9-k] ^ spike;
        @(negedge ck_1356meg);
        if (c == 13) lb_bits[9-k] = link_bit;
      end
    end
  endtask

  int t0;
  int t1;
  int v_base;
  int e_base;

  initial begin
    rst      = 1'b1;
    link_pin = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_link_bit", link_bit, 0);
    check("reset_rx_byte", rx_byte, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_err_count", err_count, 0);
    check("reset_busy", busy, 0);
    tick(10);
    check("idle_low_busy", busy, 0);

    // Clean frame 0xA5; rx_valid rises at e155 with e0 = second posedge after the drive.
    send_frame(8'hA5, 1'b0, -1, t0);
    tick(2);
    check("a5_valid_count", valid_cnt, 1);
    check("a5_valid_time", last_valid_cyc, t0 + 157);
    check("a5_byte", last_byte, 8'hA5);
    check("a5_no_err", err_pulse_cnt, 0);
    check("a5_link_bits", lb_bits, 10'b1101001010);
    check("a5_idle_busy", busy, 0);

    // Back-to-back 0x00 then 0xFF.
    send_frame(8'h00, 1'b0, -1, t0);
    send_frame(8'hFF, 1'b0, -1, t1);
    tick(2);
    check("b2b_valid_count", valid_cnt, 3);
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 160);
    check("b2b_first_byte", prev_byte, 8'h00);
    check("b2b_second_byte", last_byte, 8'hFF);

    // Start glitch: 3-clock high pulse.
    link_pin = 1'b1;
    tick(3);
    link_pin = 1'b0;
    tick(3);
    check("glitch_busy_high", busy, 1);
    tick(20);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", valid_cnt, 3);
    check("glitch_no_err", err_pulse_cnt, 0);
    check("glitch_err_count", err_count, 0);

    // Bad stop 0x3C with the line held high afterwards.
    send_frame(8'h3C, 1'b1, -1, t0);
    tick(40);
    check("badstop_err_pulses", err_pulse_cnt, 1);
    check("badstop_err_time", last_err_cyc, t0 + 157);
    check("badstop_err_count", err_count, 1);
    check("badstop_no_valid", valid_cnt, 3);
    check("badstop_no_retrigger", busy, 0);
    check("badstop_exclusive", both_cnt, 0);
    link_pin = 1'b0;
    tick(20);
    send_frame(8'h81, 1'b0, -1, t0);
    tick(2);
    check("recover_valid", valid_cnt, 4);
    check("recover_byte", last_byte, 8'h81);

    // One-clock spike at cnt = H on every data bit.
    send_frame(8'h5A, 1'b0, 9, t0);
    tick(2);
    check("vote_valid", valid_cnt, 5);
    check("vote_byte", last_byte, 8'h5A);

    // Reset during data bit 4 with the line high through release.
    link_pin = 1'b1;
    tick(16 + 16 * 4 + 8);
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(200);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_err_count", err_count, 0);
    check("rst_busy", busy, 0);
    check("rst_link_bit", link_bit, 0);
    check("rst_no_valid", valid_cnt, 5);
    check("rst_no_err", err_pulse_cnt, 1);

    // Saturation with 260 bad frames.
    v_base   = valid_cnt;
    e_base   = err_pulse_cnt;
    link_pin = 1'b0;
    tick(4);
    for (int i = 0; i < 260; i++) begin
      send_frame(8'h00, 1'b1, -1, t0);
      link_pin = 1'b0;
      tick(4);
      if (i == 0) check("sat_count_1", err_count, 1);
      if (i == 253) check("sat_count_254", err_count, 254);
      if (i == 254) check("sat_count_255", err_count, 255);
    end
    check("sat_count_final", err_count, 255);
    check("sat_err_pulses", err_pulse_cnt - e_base, 260);
    check("sat_no_valid", valid_cnt - v_base, 0);
    check("sat_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
